// File: rtl/bpu_update_queue_if.sv
// Branch predictor update bus: three resolved-branch lanes from the backend
// plus the single PHT/BTB write port toward the predictor.
interface bpu_update_queue_if #(
    parameter int IDX_W = 10
);
    logic [2:0]            in_valid;
    logic [2:0][31:0]      in_pc;
    logic [2:0][IDX_W-1:0] in_idx;
    logic [2:0]            in_taken;
    logic [2:0][31:0]      in_target;
    logic                  in_ready;

    logic                  wr_en;
    logic                  wr_init;
    logic [IDX_W-1:0]      wr_idx;
    logic [31:0]           wr_pc;
    logic                  wr_taken;
    logic [31:0]           wr_target;
    logic                  wr_ready;

    // Environment side: backend lanes in, predictor write port out
    modport master (
        output in_valid, in_pc, in_idx, in_taken, in_target,
        input  in_ready,
        input  wr_en, wr_init, wr_idx, wr_pc, wr_taken, wr_target,
        output wr_ready
    );

    // Queue side
    modport slave (
        input  in_valid, in_pc, in_idx, in_taken, in_target,
        output in_ready,
        output wr_en, wr_init, wr_idx, wr_pc, wr_taken, wr_target,
        input  wr_ready
    );
endinterface

// File: rtl/bpu_update_queue.sv
// Sequences every write into the branch predictor update port: an init sweep
// over all PHT indices, then resolved-branch updates buffered in a circular
// FIFO (up to 3 pushes per cycle, 1 drain per cycle).
module bpu_update_queue #(
    parameter int DEPTH       = 8,
    parameter int PHT_ENTRIES = 1024,
    parameter int IDX_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reinit,
    bpu_update_queue_if.slave bus,
    output logic              init_busy,
    output logic              overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] SWEEP_LAST = IDX_W'(PHT_ENTRIES - 1);

    typedef enum logic [1:0] {
        BOOT,
        INIT,
        RUN
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  sweep;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic [31:0]       mem_pc     [DEPTH];
    logic [IDX_W-1:0]  mem_idx    [DEPTH];
    logic              mem_taken  [DEPTH];
    logic [31:0]       mem_target [DEPTH];

    logic              reinit_take;
    logic              push_ok;
    logic              pop;
    logic              drop;
    logic [1:0]        push_cnt;
    logic [PTR_W-1:0]  slot [3];

    // Queue has room for a full 3-lane group only while running
    assign bus.in_ready = (state == RUN) && (count <= CNT_W'(DEPTH - 3));

    // Handshake decode: a reinit cycle discards any incoming lanes silently
    always_comb begin
        reinit_take = reinit && (state != BOOT);
        push_ok     = bus.in_ready && !reinit_take;
        pop         = (state == RUN) && (count != '0) && bus.wr_ready;
        drop        = (|bus.in_valid) && !bus.in_ready && !reinit_take;
        push_cnt    = 2'(bus.in_valid[0]) + 2'(bus.in_valid[1]) + 2'(bus.in_valid[2]);
        if (!push_ok) begin
            push_cnt = 2'd0;
        end
        slot[0] = tail;
        slot[1] = tail + PTR_W'(bus.in_valid[0]);
        slot[2] = tail + PTR_W'(bus.in_valid[0]) + PTR_W'(bus.in_valid[1]);
    end

    // Write port and status outputs decoded from the registered state
    always_comb begin
        bus.wr_en     = 1'b0;
        bus.wr_init   = 1'b0;
        bus.wr_idx    = '0;
        bus.wr_pc     = '0;
        bus.wr_taken  = 1'b0;
        bus.wr_target = '0;
        init_busy     = 1'b0;
        case (state)
            BOOT: begin
                init_busy = 1'b1;
            end
            INIT: begin
                init_busy   = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_init = 1'b1;
                bus.wr_idx  = sweep;
            end
            RUN: begin
                bus.wr_en     = (count != '0);
                bus.wr_idx    = mem_idx[head];
                bus.wr_pc     = mem_pc[head];
                bus.wr_taken  = mem_taken[head];
                bus.wr_target = mem_target[head];
            end
            default: begin
                init_busy = 1'b1;
            end
        endcase
    end

    // Compacted lane storage: valid lanes take consecutive slots from tail
    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int l = 0; l < 3; l++) begin
                if (bus.in_valid[l]) begin
                    mem_pc[slot[l]]     <= bus.in_pc[l];
                    mem_idx[slot[l]]    <= bus.in_idx[l];
                    mem_taken[slot[l]]  <= bus.in_taken[l];
                    mem_target[slot[l]] <= bus.in_target[l];
                end
            end
        end
    end

    // Mode sequencing, sweep counter, FIFO pointers and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            sweep    <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (reinit_take) begin
                state <= INIT;
                sweep <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                case (state)
                    BOOT: begin
                        state <= INIT;
                    end
                    INIT: begin
                        if (sweep == SWEEP_LAST) begin
                            sweep <= '0;
                            state <= RUN;
                        end else begin
                            sweep <= sweep + 1'b1;
                        end
                    end
                    RUN: begin
                        head  <= head + PTR_W'(pop);
                        tail  <= tail + PTR_W'(push_cnt);
                        count <= count + CNT_W'(push_cnt) - CNT_W'(pop);
                    end
                    default: begin
                        state <= BOOT;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bpu_update_queue.sv
// Scoreboard bench for bpu_update_queue: stimulus pushes the writes it expects
// the predictor to see, a negedge monitor pops and compares each accepted write.
module tb_bpu_update_queue;
    localparam int IDX_W = 10;

    typedef struct packed {
        logic             init;
        logic [IDX_W-1:0] idx;
        logic [31:0]      pc;
        logic             taken;
        logic [31:0]      target;
    } wr_t;

    logic clk;
    logic rst;
    logic reinit;
    logic init_busy;
    logic overflow;

    wr_t exp_q[$];
    int  n_checks;
    int  n_fail;

    bpu_update_queue_if #(.IDX_W(IDX_W)) bus ();

    bpu_update_queue #(
        .DEPTH(8),
        .PHT_ENTRIES(1024),
        .IDX_W(IDX_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .reinit(reinit),
        .bus(bus),
        .init_busy(init_busy),
        .overflow(overflow)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: every write the predictor accepts must match the scoreboard head
    always @(negedge clk) begin
        wr_t got;
        wr_t want;
        if (rst && bus.wr_en && (bus.wr_init || bus.wr_ready)) begin
            got = '{bus.wr_init, bus.wr_idx, bus.wr_pc, bus.wr_taken, bus.wr_target};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL sb_unexpected: got %h, required no write", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("[TB] FAIL sb_write: got %h, required %h", got, want);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Drive the three lanes; when accepted, queue the expected writes in lane order
    task automatic applyStimulus(input logic [2:0] v, input logic [31:0] pc_base,
                                 input logic [IDX_W-1:0] i0, input logic [IDX_W-1:0] i1,
                                 input logic [IDX_W-1:0] i2, input logic accept);
        logic [IDX_W-1:0] idx [3];
        idx[0] = i0;
        idx[1] = i1;
        idx[2] = i2;
        for (int l = 0; l < 3; l++) begin
            bus.in_valid[l]  = v[l];
            bus.in_pc[l]     = pc_base + 32'(4 * l);
            bus.in_idx[l]    = idx[l];
            bus.in_taken[l]  = (l != 0);
            bus.in_target[l] = pc_base + 32'h100 + 32'(16 * l);
            if (accept && v[l]) begin
                exp_q.push_back('{1'b0, idx[l], pc_base + 32'(4 * l), (l != 0),
                                  pc_base + 32'h100 + 32'(16 * l)});
            end
        end
    endtask

    task automatic expectSweep();
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back('{1'b1, IDX_W'(i), 32'd0, 1'b0, 32'd0});
        end
    endtask

    task automatic waitInitDone(input int expected_cycles);
        int n;
        n = 0;
        while (init_busy && n < 1100) begin
            tick();
            n++;
        end
        checkOutput("init_length", 64'(n), 64'(expected_cycles));
    endtask

    // Directed sequence
    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b0;
        reinit       = 1'b0;
        bus.wr_ready = 1'b0;
        applyStimulus(3'b000, 32'h0, '0, '0, '0, 1'b0);

        // Reset and boot
        tick();
        tick();
        checkOutput("reset_wr_en", 64'(bus.wr_en), 64'd0);
        checkOutput("reset_init_busy", 64'(init_busy), 64'd1);
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("reset_overflow", 64'(overflow), 64'd0);
        expectSweep();
        rst = 1'b1;
        #1;
        checkOutput("boot_wr_en", 64'(bus.wr_en), 64'd0);
        checkOutput("boot_init_busy", 64'(init_busy), 64'd1);
        waitInitDone(1025);
        checkOutput("run_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("run_wr_en_idle", 64'(bus.wr_en), 64'd0);
        checkOutput("sweep_drained", 64'(exp_q.size()), 64'd0);

        // Sparse lanes 0 and 2, no bypass
        bus.wr_ready = 1'b1;
        applyStimulus(3'b101, 32'h1C00_0000, 10'h012, 10'h3FF, 10'h034, 1'b1);
        #1;
        checkOutput("no_bypass", 64'(bus.wr_en), 64'd0);
        tick();
        applyStimulus(3'b000, 32'h0, '0, '0, '0, 1'b0);
        checkOutput("first_pc", 64'(bus.wr_pc), 64'h1C00_0000);
        checkOutput("first_idx", 64'(bus.wr_idx), 64'h012);
        tick();
        checkOutput("second_pc", 64'(bus.wr_pc), 64'h1C00_0008);
        checkOutput("second_idx", 64'(bus.wr_idx), 64'h034);
        tick();
        checkOutput("sparse_drained_wr_en", 64'(bus.wr_en), 64'd0);

        // Fill to 6 while stalled
        bus.wr_ready = 1'b0;
        applyStimulus(3'b111, 32'h1C00_1000, 10'h100, 10'h101, 10'h102, 1'b1);
        tick();
        checkOutput("in_ready_at_3", 64'(bus.in_ready), 64'd1);
        applyStimulus(3'b111, 32'h1C00_2000, 10'h110, 10'h111, 10'h112, 1'b1);
        tick();
        applyStimulus(3'b000, 32'h0, '0, '0, '0, 1'b0);
        checkOutput("in_ready_at_6", 64'(bus.in_ready), 64'd0);
        checkOutput("stall_wr_en", 64'(bus.wr_en), 64'd1);
        checkOutput("stall_pc", 64'(bus.wr_pc), 64'h1C00_1000);

        // Dropped lane sets sticky overflow
        applyStimulus(3'b001, 32'h2D00_0000, 10'h3FE, '0, '0, 1'b0);
        tick();
        applyStimulus(3'b000, 32'h0, '0, '0, '0, 1'b0);
        checkOutput("overflow_set", 64'(overflow), 64'd1);
        checkOutput("in_ready_still_6", 64'(bus.in_ready), 64'd0);
        tick();
        checkOutput("stall_pc_hold", 64'(bus.wr_pc), 64'h1C00_1000);
        checkOutput("stall_idx_hold", 64'(bus.wr_idx), 64'h100);
        bus.wr_ready = 1'b1;
        tick();
        checkOutput("in_ready_at_5", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("drain_wr_en", 64'(bus.wr_en), 64'd0);
        checkOutput("overflow_sticky", 64'(overflow), 64'd1);

        // Push at count 5 with simultaneous pop, tail wraps
        bus.wr_ready = 1'b0;
        applyStimulus(3'b111, 32'h1C00_3000, 10'h120, 10'h121, 10'h122, 1'b1);
        tick();
        applyStimulus(3'b011, 32'h1C00_4000, 10'h130, 10'h131, 10'h132, 1'b1);
        tick();
        applyStimulus(3'b000, 32'h0, '0, '0, '0, 1'b0);
        checkOutput("in_ready_fill_5", 64'(bus.in_ready), 64'd1);
        bus.wr_ready = 1'b1;
        applyStimulus(3'b111, 32'h1C00_5000, 10'h140, 10'h141, 10'h142, 1'b1);
        tick();
        applyStimulus(3'b000, 32'h0, '0, '0, '0, 1'b0);
        checkOutput("in_ready_at_7", 64'(bus.in_ready), 64'd0);
        checkOutput("head_advanced_pc", 64'(bus.wr_pc), 64'h1C00_3004);
        tick();
        tick();
        checkOutput("in_ready_back_5", 64'(bus.in_ready), 64'd1);
        applyStimulus(3'b111, 32'h1C00_6000, 10'h150, 10'h151, 10'h152, 1'b1);
        tick();
        applyStimulus(3'b000, 32'h0, '0, '0, '0, 1'b0);
        checkOutput("in_ready_at_7_wrap", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("wrap_drained_wr_en", 64'(bus.wr_en), 64'd0);
        checkOutput("wrap_drained_sb", 64'(exp_q.size()), 64'd0);

        // Reinit from RUN with count 4 and all lanes valid
        bus.wr_ready = 1'b0;
        applyStimulus(3'b111, 32'h1C00_7000, 10'h160, 10'h161, 10'h162, 1'b1);
        tick();
        applyStimulus(3'b001, 32'h1C00_8000, 10'h170, '0, '0, 1'b1);
        tick();
        checkOutput("in_ready_at_4", 64'(bus.in_ready), 64'd1);
        applyStimulus(3'b111, 32'hDEAD_0000, 10'h3A0, 10'h3A1, 10'h3A2, 1'b0);
        reinit = 1'b1;
        @(negedge clk);
        #1;
        exp_q.delete();
        expectSweep();
        tick();
        reinit = 1'b0;
        applyStimulus(3'b000, 32'h0, '0, '0, '0, 1'b0);
        checkOutput("reinit_wr_init", 64'(bus.wr_init), 64'd1);
        checkOutput("reinit_wr_idx", 64'(bus.wr_idx), 64'd0);
        checkOutput("reinit_overflow", 64'(overflow), 64'd1);
        checkOutput("reinit_in_ready", 64'(bus.in_ready), 64'd0);
        waitInitDone(1024);
        checkOutput("resweep_wr_en", 64'(bus.wr_en), 64'd0);
        checkOutput("resweep_sb", 64'(exp_q.size()), 64'd0);

        // Reset mid-run clears overflow; reinit during INIT restarts the sweep
        rst = 1'b0;
        #1;
        checkOutput("midreset_overflow", 64'(overflow), 64'd0);
        checkOutput("midreset_init_busy", 64'(init_busy), 64'd1);
        checkOutput("midreset_wr_en", 64'(bus.wr_en), 64'd0);
        expectSweep();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        applyStimulus(3'b111, 32'hBEEF_0000, 10'h3B0, 10'h3B1, 10'h3B2, 1'b0);
        reinit = 1'b1;
        @(negedge clk);
        #1;
        exp_q.delete();
        expectSweep();
        tick();
        reinit = 1'b0;
        applyStimulus(3'b000, 32'h0, '0, '0, '0, 1'b0);
        checkOutput("init_reinit_idx", 64'(bus.wr_idx), 64'd0);
        checkOutput("reinit_no_overflow", 64'(overflow), 64'd0);
        waitInitDone(1024);
        checkOutput("final_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("final_sb", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bpu_update_queue.md
Name: bpu_update_queue

Overview:
- Sequences all writes into the branch predictor's PHT/BTB update port.
- After reset, or on request, sweeps every PHT index to a known initial state.
- Afterwards accepts up to 3 resolved-branch updates per cycle from the backend and buffers them in a circular FIFO.
- Drains one update per cycle to the predictor's single write port under a valid/ready handshake.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 4
PHT_ENTRIES, 1024, number of PHT indices swept during init
IDX_W, 10, PHT index width; log2(PHT_ENTRIES)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset (0 = reset)
reinit  in  1  pulse: discard queue, restart init sweep
in_valid[2:0]  in  1 each  lane update valid
in_pc[2:0]  in  32 each  branch PC
in_idx[2:0]  in  IDX_W each  PHT index used at prediction
in_taken[2:0]  in  1 each  resolved direction
in_target[2:0]  in  32 each  resolved target
in_ready  out  1  queue can accept 3 lanes this cycle
wr_en  out  1  write request to predictor
wr_init  out  1  current write is an init-sweep write
wr_idx  out  IDX_W  PHT index to write
wr_pc  out  32  PC for BTB tag/entry
wr_taken  out  1  direction to train
wr_target  out  32  target to install
wr_ready  in  1  predictor accepts write (RUN state only)
init_busy  out  1  init sweep in progress
overflow  out  1  sticky: input dropped while in_ready=0

Behaviour:
- States: BOOT, INIT, RUN. Async reset: state=BOOT, sweep counter=0, head=tail=count=0, overflow=0.
- BOOT:
  - All outputs 0, in_ready=0, init_busy=1.
  - Moves to INIT on the first clk edge after rst deasserts.
- INIT:
  - wr_en=1, wr_init=1, wr_idx=counter, wr_taken=0, wr_pc=0, wr_target=0.
  - wr_ready is ignored; counter increments each cycle.
  - After counter = PHT_ENTRIES-1 is written, moves to RUN and counter returns to 0.
  - in_ready=0; init_busy=1.
- RUN:
  - init_busy=0, wr_init=0.
  - wr_en = (count != 0); wr_* are driven combinationally from the head entry.
  - Pop when wr_en & wr_ready.
- Enqueue (RUN only):
  - in_ready = (count <= DEPTH-3), combinational from the registered count.
  - When in_ready=1, valid lanes are written in lane order 0,1,2, compacted (invalid lanes consume no slot).
  - tail advances by popcount(in_valid).
- Pointers and count:
  - head and tail wrap modulo DEPTH.
  - count_next = count + pushes - pop; a simultaneous push and pop are both honored.
- No bypass: an entry pushed at cycle N appears on wr_* no earlier than N+1.
- Overflow:
  - Any in_valid lane while in_ready=0 (any state) is dropped.
  - overflow sets and stays 1 until reset.
  - reinit does not clear overflow.
  - Exception: in_valid in the same cycle as reinit is dropped without setting overflow.
- reinit (sampled at clk, any state except BOOT):
  - Next cycle: head=tail=count=0, state=INIT, counter=0.
  - An in-progress pop that cycle still completes at the port, but its entry is discarded with the queue.
  - reinit during INIT restarts the sweep at index 0.
- wr_* hold stable while wr_en=1 and wr_ready=0 (head unchanged).
- Reset asserted mid-operation: immediate return to BOOT values; the queue is lost.

Test Plan:
1. Release rst at cycle 0 → cycle 1 BOOT, wr_en=0. Cycles 2..1025: wr_en=1, wr_init=1, wr_idx=0..1023. Cycle 1026: init_busy=0, in_ready=1, wr_en=0.
2. RUN, empty, wr_ready=1; in_valid=3'b101, pc0=0x1C000000, pc2=0x1C000008, idx 0x012/0x034 → next cycle wr_pc=0x1C000000, wr_idx=0x012; following cycle wr_pc=0x1C000008, wr_idx=0x034; then wr_en=0.
3. wr_ready=0; push 3 valid lanes on two consecutive cycles → count=6, in_ready=0. The head entry's wr_* stay stable. Raise wr_ready → entries drain in push order; in_ready returns at count=5.
4. count=6, wr_ready=0, drive in_valid=3'b001 → entry dropped, count stays 6, overflow=1 and stays 1 after the queue drains.
5. count=5, push 3 lanes with wr_ready=1 the same cycle → count=7 and head advances by 1. Repeat with wrap: tail crosses DEPTH-1→0, and order is preserved.
6. RUN, count=4, assert reinit with in_valid=3'b111 → next cycle count=0, wr_init=1, wr_idx=0, overflow unchanged. The sweep completes 1024 writes, and no dropped-lane data ever appears on wr_*.
